// File: rtl/vscale_wb_stage.sv
// EX->WB pipeline register and writeback formatter (ALU / load / CSR select).
// Optional WB->EX forwarding outputs when VSCALE_WB_BYPASS_EN is defined.
module vscale_wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_alu_out,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wen,
    input  logic [1:0]        ex_wb_src,
    input  logic [2:0]        ex_mem_type,
    input  logic [XLEN-1:0]   ex_csr_rdata,
    input  logic              kill_wb,
    input  logic              stall_ext,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_wait,
    output logic              wb_valid,
    output logic              wb_wen,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_misalign,
    output logic              stall_ex
`ifdef VSCALE_WB_BYPASS_EN
    ,
    output logic              byp_valid,
    output logic [REG_AW-1:0] byp_rd,
    output logic [XLEN-1:0]   byp_data
`endif
);

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_CSR = 2'd2,
        SRC_RSV = 2'd3
    } wb_src_e;

    typedef enum logic [2:0] {
        MT_LB  = 3'd0,
        MT_LH  = 3'd1,
        MT_LW  = 3'd2,
        MT_LBU = 3'd4,
        MT_LHU = 3'd5
    } mem_type_e;

    logic              valid_q;
    logic [XLEN-1:0]   alu_q;
    logic [REG_AW-1:0] rd_q;
    logic              wen_q;
    logic [1:0]        src_q;
    logic [2:0]        mtype_q;
    logic [XLEN-1:0]   csr_q;

    logic              is_load;
    logic              load_wait;
    logic              stall_wb;
    logic [1:0]        off;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [XLEN-1:0]   load_data;
    logic              misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            src_q   <= '0;
            mtype_q <= '0;
            csr_q   <= '0;
        end else if (!stall_wb) begin
            valid_q <= ex_valid & ~kill_wb;
            alu_q   <= ex_alu_out;
            rd_q    <= ex_rd;
            wen_q   <= ex_wen;
            src_q   <= ex_wb_src;
            mtype_q <= ex_mem_type;
            csr_q   <= ex_csr_rdata;
        end else if (kill_wb) begin
            // A kill overrides the hold: the stalled instruction is squashed.
            valid_q <= 1'b0;
        end
    end

    assign is_load   = valid_q & (src_q == SRC_MEM);
    assign load_wait = is_load & dmem_wait;
    assign stall_wb  = load_wait | stall_ext;
    assign stall_ex  = stall_wb;
    assign off       = alu_q[1:0];

    always_comb begin
        byte_sel  = '0;
        half_sel  = '0;
        load_data = '0;
        misalign  = 1'b0;
        case (off)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (mtype_q)
            MT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            MT_LBU:  load_data = {24'd0, byte_sel};
            MT_LH: begin
                load_data = {{16{half_sel[15]}}, half_sel};
                misalign  = off[0];
            end
            MT_LHU: begin
                load_data = {16'd0, half_sel};
                misalign  = off[0];
            end
            default: begin
                load_data = dmem_rdata;
                misalign  = (off != 2'd0);
            end
        endcase
    end

    assign wb_misalign = is_load & misalign;
    assign wb_valid    = valid_q;
    assign wb_rd       = rd_q;
    assign wb_wen      = valid_q & wen_q & (rd_q != '0) & ~stall_wb & ~wb_misalign;

    always_comb begin
        wb_data = '0;
        if (valid_q) begin
            case (src_q)
                SRC_MEM: wb_data = load_data;
                SRC_CSR: wb_data = csr_q;
                default: wb_data = alu_q;
            endcase
        end
    end

`ifdef VSCALE_WB_BYPASS_EN
    assign byp_valid = wb_wen;
    assign byp_rd    = wb_rd;
    assign byp_data  = wb_data;
`endif

endmodule
